// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : Command sequencer behind uart_rx. Parses 4-byte write frames
//               {SYNC, ADDR, DATA, CHK} from the received byte stream and
//               issues one register-bus write per good frame using a req/ack
//               handshake. Reports checksum errors, inter-byte timeouts and
//               ack timeouts, and keeps a saturating error count.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl #(
  parameter int          CLK_FREQ       = 50000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = CLK_FREQ / 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  input  logic       reg_ack,
  output logic       busy,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] err_count,
  output logic       rx_drop
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  // Last timer value before a timeout fires; the state is left on this cycle.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_CHK      = 2'b01;
  localparam logic [1:0] ERR_BYTE_TO  = 2'b10;
  localparam logic [1:0] ERR_ACK_TO   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHK   = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t          state_q,     state_d;
  logic [7:0]      addr_q,      addr_d;
  logic [7:0]      data_q,      data_d;
  logic [7:0]      chk_q,       chk_d;
  logic [TO_W-1:0] timer_q,     timer_d;
  logic [7:0]      reg_addr_q,  reg_addr_d;
  logic [7:0]      reg_wdata_q, reg_wdata_d;
  logic            reg_wr_q,    reg_wr_d;
  logic            busy_q,      busy_d;
  logic            frame_ok_q,  frame_ok_d;
  logic            frame_err_q, frame_err_d;
  logic [1:0]      err_code_q,  err_code_d;
  logic [7:0]      err_count_q, err_count_d;
  logic            rx_drop_q,   rx_drop_d;

  logic            timer_exp;
  logic            err_hit;
  logic [1:0]      err_kind;

  assign timer_exp = (timer_q == TO_LAST);

  // Next-state and next-output computation for the frame parser.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    chk_d       = chk_q;
    timer_d     = timer_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = reg_wr_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    rx_drop_d   = 1'b0;
    err_code_d  = err_code_q;
    err_count_d = err_count_q;
    err_hit     = 1'b0;
    err_kind    = 2'b00;

    case (state_q)
      ST_IDLE: begin
        // Timer is held idle here; non-sync bytes are silently ignored.
        timer_d = '0;
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = ST_ADDR;
          chk_d   = SYNC_BYTE;
        end
      end

      ST_ADDR: begin
        // A sync value here is plain address data; no resynchronisation.
        if (rx_valid) begin
          addr_d  = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = ST_DATA;
          timer_d = '0;
        end else if (timer_exp) begin
          state_d  = ST_IDLE;
          timer_d  = '0;
          err_hit  = 1'b1;
          err_kind = ERR_BYTE_TO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (rx_valid) begin
          data_d  = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = ST_CHK;
          timer_d = '0;
        end else if (timer_exp) begin
          state_d  = ST_IDLE;
          timer_d  = '0;
          err_hit  = 1'b1;
          err_kind = ERR_BYTE_TO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_CHK: begin
        if (rx_valid) begin
          timer_d = '0;
          if (rx_data == chk_q) begin
            state_d     = ST_WRITE;
            reg_wr_d    = 1'b1;
            reg_addr_d  = addr_q;
            reg_wdata_d = data_q;
          end else begin
            state_d  = ST_IDLE;
            err_hit  = 1'b1;
            err_kind = ERR_CHK;
          end
        end else if (timer_exp) begin
          state_d  = ST_IDLE;
          timer_d  = '0;
          err_hit  = 1'b1;
          err_kind = ERR_BYTE_TO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_WRITE: begin
        // Priority: ack beats a stray byte, a stray byte beats the timeout.
        if (reg_ack && reg_wr_q) begin
          reg_wr_d   = 1'b0;
          frame_ok_d = 1'b1;
          state_d    = ST_IDLE;
          timer_d    = '0;
        end else if (rx_valid) begin
          rx_drop_d = 1'b1;
          timer_d   = '0;
        end else if (timer_exp) begin
          reg_wr_d = 1'b0;
          state_d  = ST_IDLE;
          timer_d  = '0;
          err_hit  = 1'b1;
          err_kind = ERR_ACK_TO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        timer_d  = '0;
        reg_wr_d = 1'b0;
      end
    endcase

    if (err_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = err_kind;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset returns everything to zero at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      chk_q       <= 8'h00;
      timer_q     <= '0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
      err_count_q <= 8'h00;
      rx_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      chk_q       <= chk_d;
      timer_q     <= timer_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      busy_q      <= busy_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
      rx_drop_q   <= rx_drop_d;
    end
  end

  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr    = reg_wr_q;
  assign busy      = busy_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;
  assign rx_drop   = rx_drop_q;

endmodule
`default_nettype wire
